// File: rtl/ex_stage.sv
// Execute stage: forwarding operand select, ALU, iterative shift-add multiplier
// and the EX/MEM pipeline register (whose ALU result doubles as the MEM forward source).

module fwd_mux #(
  parameter int DW = 32
) (
  input  logic [1:0]    sel,
  input  logic [DW-1:0] rd,
  input  logic [DW-1:0] mem_fwd,
  input  logic [DW-1:0] wb_fwd,
  output logic [DW-1:0] y
);
  always_comb begin
    y = rd;
    case (sel)
      2'b10:   y = mem_fwd;
      2'b01:   y = wb_fwd;
      default: y = rd;
    endcase
  end
endmodule

module ex_stage #(
  parameter int DW = 32,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [DW-1:0] id_rd1,
  input  logic [DW-1:0] id_rd2,
  input  logic [DW-1:0] id_imm,
  input  logic          id_alusrc,
  input  logic [3:0]    id_aluop,
  input  logic [RW-1:0] id_wn,
  input  logic          id_enrw,
  input  logic          id_memrd,
  input  logic          id_memwr,
  input  logic [1:0]    FA,
  input  logic [1:0]    FB,
  input  logic [DW-1:0] wb_fwd_data,
  input  logic          ex_flush,
  output logic          ex_busy,
  output logic          mem_valid,
  output logic          mem_enrw,
  output logic          mem_memrd,
  output logic          mem_memwr,
  output logic [DW-1:0] mem_alu,
  output logic [DW-1:0] mem_store_data,
  output logic [RW-1:0] mem_wn
);
  localparam int SW = $clog2(DW);
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
  state_t state, state_nxt;

  // operand forwarding: index 0 is A (FA/rd1), index 1 is B (FB/rd2)
  logic [1:0][DW-1:0] rd_v, fwd_v;
  logic [1:0][1:0]    sel_v;
  assign rd_v  = {id_rd2, id_rd1};
  assign sel_v = {FB, FA};

  for (genvar i = 0; i < 2; i++) begin : g_fwd
    fwd_mux #(.DW(DW)) u_mux (
      .sel     (sel_v[i]),
      .rd      (rd_v[i]),
      .mem_fwd (mem_alu),
      .wb_fwd  (wb_fwd_data),
      .y       (fwd_v[i])
    );
  end

  logic [DW-1:0] opa, opb_fwd, opb, alu_res;
  logic [SW-1:0] shamt;
  assign opa     = fwd_v[0];
  assign opb_fwd = fwd_v[1];
  assign opb     = id_alusrc ? id_imm : opb_fwd;
  assign shamt   = opb[SW-1:0];

  // MUL yields 0 here; its result comes from the multiplier in DONE
  always_comb begin
    alu_res = '0;
    case (id_aluop)
      4'd0: alu_res = opa + opb;
      4'd1: alu_res = opa - opb;
      4'd2: alu_res = opa & opb;
      4'd3: alu_res = opa | opb;
      4'd4: alu_res = opa ^ opb;
      4'd5: alu_res = {{(DW-1){1'b0}}, ($signed(opa) < $signed(opb))};
      4'd6: alu_res = opa << shamt;
      4'd7: alu_res = opa >> shamt;
      default: alu_res = '0;
    endcase
  end

  logic          mul_start;
  logic [DW-1:0] mul_a, mul_b, acc, store_q;
  logic [SW-1:0] cnt;

  assign mul_start = (state == S_IDLE) && id_valid && (id_aluop == OP_MUL) && !ex_flush;
  assign ex_busy   = mul_start || (state == S_MUL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (mul_start) state_nxt = S_MUL;
      S_MUL:  if (cnt == SW'(DW-1)) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (ex_flush) state_nxt = S_IDLE;
  end

  // one multiplier bit per cycle; operands frozen at start so forwarding can't disturb it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a   <= '0;
      mul_b   <= '0;
      acc     <= '0;
      store_q <= '0;
      cnt     <= '0;
    end else if (mul_start) begin
      mul_a   <= opa;
      mul_b   <= opb;
      acc     <= '0;
      store_q <= opb_fwd;
      cnt     <= '0;
    end else if (state == S_MUL) begin
      acc   <= acc + (mul_b[0] ? mul_a : '0);
      mul_a <= mul_a << 1;
      mul_b <= mul_b >> 1;
      cnt   <= cnt + SW'(1);
    end
  end

  logic bubble;
  assign bubble = ex_flush || mul_start || (state == S_MUL) || !id_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid      <= 1'b0;
      mem_enrw       <= 1'b0;
      mem_memrd      <= 1'b0;
      mem_memwr      <= 1'b0;
      mem_alu        <= '0;
      mem_store_data <= '0;
      mem_wn         <= '0;
    end else if (bubble) begin
      mem_valid <= 1'b0;
      mem_enrw  <= 1'b0;
      mem_memrd <= 1'b0;
      mem_memwr <= 1'b0;
    end else begin
      mem_valid      <= 1'b1;
      mem_enrw       <= id_enrw;
      mem_memrd      <= id_memrd;
      mem_memwr      <= id_memwr;
      mem_alu        <= (state == S_DONE) ? acc : alu_res;
      mem_store_data <= (state == S_DONE) ? store_q : opb_fwd;
      mem_wn         <= id_wn;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed vector table, multicycle multiply/flush/reset
// sequences, and randomized traffic against a behavioural model.

module tb_ex_stage;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        id_valid = 0, id_alusrc = 0, id_enrw = 0, id_memrd = 0, id_memwr = 0, ex_flush = 0;
  logic [31:0] id_rd1 = 0, id_rd2 = 0, id_imm = 0, wb_fwd_data = 0;
  logic [3:0]  id_aluop = 0, id_wn = 0;
  logic [1:0]  FA = 0, FB = 0;
  logic        ex_busy, mem_valid, mem_enrw, mem_memrd, mem_memwr;
  logic [31:0] mem_alu, mem_store_data;
  logic [3:0]  mem_wn;

  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  ex_stage #(.DW(32), .RW(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm(id_imm), .id_alusrc(id_alusrc), .id_aluop(id_aluop), .id_wn(id_wn),
    .id_enrw(id_enrw), .id_memrd(id_memrd), .id_memwr(id_memwr), .FA(FA), .FB(FB),
    .wb_fwd_data(wb_fwd_data), .ex_flush(ex_flush), .ex_busy(ex_busy),
    .mem_valid(mem_valid), .mem_enrw(mem_enrw), .mem_memrd(mem_memrd),
    .mem_memwr(mem_memwr), .mem_alu(mem_alu), .mem_store_data(mem_store_data),
    .mem_wn(mem_wn)
  );

  typedef struct {
    logic [31:0] rd1, rd2, imm, wb;
    logic        alusrc;
    logic [3:0]  op, wn;
    logic [1:0]  fa, fb;
    logic [31:0] exp_alu, exp_st;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // behavioural ALU straight from the opcode table
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a; sb = b;
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return (sa < sb) ? 32'd1 : 32'd0;
      4'd6: return a << (b % 32);
      4'd7: return a >> (b % 32);
      4'd8: return 32'(64'(a) * 64'(b));
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] rd, input logic [31:0] m, input logic [31:0] w);
    if (s == 2'b10) return m;
    if (s == 2'b01) return w;
    return rd;
  endfunction

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] rd1, input logic [31:0] rd2,
                              input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] wb,
                              input logic alusrc, input logic [31:0] imm, input logic [3:0] wn,
                              input logic [31:0] exp_alu, input logic [31:0] exp_st);
    vec_t v;
    v.op = op; v.rd1 = rd1; v.rd2 = rd2; v.fa = fa; v.fb = fb; v.wb = wb;
    v.alusrc = alusrc; v.imm = imm; v.wn = wn; v.exp_alu = exp_alu; v.exp_st = exp_st;
    return v;
  endfunction

  // model of the EX/MEM register contents
  logic [31:0] m_alu, m_st;
  logic [3:0]  m_wn;

  initial begin
    vec_t vt[17];
    int busy_n, bub_n, waited;
    logic seen;
    logic [31:0] a, b, bf, held;

    vt[0]  = mk(4'd0, 32'd5, 32'd7, 2'b00, 2'b00, 32'd0, 1'b0, 32'd0, 4'd3, 32'd12, 32'd7);
    vt[1]  = mk(4'd0, 32'd2, 32'd3, 2'b00, 2'b00, 32'd0, 1'b0, 32'd0, 4'd1, 32'd5, 32'd3);
    vt[2]  = mk(4'd1, 32'd99, 32'd1, 2'b10, 2'b00, 32'd0, 1'b0, 32'd0, 4'd2, 32'd4, 32'd1);
    vt[3]  = mk(4'd1, 32'd99, 32'd1, 2'b10, 2'b01, 32'd40, 1'b0, 32'd0, 4'd2, 32'hFFFF_FFDC, 32'd40);
    vt[4]  = mk(4'd0, 32'd2, 32'd1, 2'b00, 2'b01, 32'd40, 1'b1, 32'd8, 4'd4, 32'd10, 32'd40);
    vt[5]  = mk(4'd5, 32'hFFFF_FFFF, 32'd1, 2'b00, 2'b00, 32'd0, 1'b0, 32'd0, 4'd5, 32'd1, 32'd1);
    vt[6]  = mk(4'd5, 32'd1, 32'hFFFF_FFFF, 2'b00, 2'b00, 32'd0, 1'b0, 32'd0, 4'd5, 32'd0, 32'hFFFF_FFFF);
    vt[7]  = mk(4'd7, 32'h8000_0000, 32'd31, 2'b00, 2'b00, 32'd0, 1'b0, 32'd0, 4'd6, 32'd1, 32'd31);
    vt[8]  = mk(4'd6, 32'd1, 32'd33, 2'b00, 2'b00, 32'd0, 1'b0, 32'd0, 4'd7, 32'd2, 32'd33);
    vt[9]  = mk(4'd2, 32'hF0F0, 32'hFF00, 2'b00, 2'b00, 32'd0, 1'b0, 32'd0, 4'd8, 32'hF000, 32'hFF00);
    vt[10] = mk(4'd3, 32'hF0F0, 32'hFF00, 2'b00, 2'b00, 32'd0, 1'b0, 32'd0, 4'd9, 32'hFFF0, 32'hFF00);
    vt[11] = mk(4'd4, 32'hF0F0, 32'hFF00, 2'b00, 2'b00, 32'd0, 1'b0, 32'd0, 4'd10, 32'h0FF0, 32'hFF00);
    vt[12] = mk(4'd9, 32'd6, 32'd3, 2'b00, 2'b00, 32'd0, 1'b0, 32'd0, 4'd11, 32'd0, 32'd3);
    vt[13] = mk(4'd15, 32'd6, 32'd3, 2'b00, 2'b00, 32'd0, 1'b0, 32'd0, 4'd12, 32'd0, 32'd3);
    vt[14] = mk(4'd0, 32'hFFFF_FFFF, 32'd2, 2'b00, 2'b00, 32'd0, 1'b0, 32'd0, 4'd13, 32'd1, 32'd2);
    vt[15] = mk(4'd0, 32'd7, 32'd1, 2'b11, 2'b11, 32'd100, 1'b0, 32'd0, 4'd14, 32'd8, 32'd1);
    vt[16] = mk(4'd1, 32'd0, 32'd1, 2'b00, 2'b00, 32'd0, 1'b0, 32'd0, 4'd15, 32'hFFFF_FFFF, 32'd1);

    // reset with random inputs
    for (int i = 0; i < 4; i++) begin
      id_valid = 1'($urandom); id_rd1 = $urandom; id_rd2 = $urandom; id_aluop = 4'($urandom);
      id_enrw = 1'($urandom); FA = 2'($urandom); FB = 2'($urandom); wb_fwd_data = $urandom;
      tick();
    end
    id_valid = 0; ex_flush = 0; FA = 0; FB = 0; id_aluop = 0; id_alusrc = 0;
    #2 rst_n = 1'b1;
    #1;
    chk("rst_valid", mem_valid, 0);
    chk("rst_ctl", {mem_enrw, mem_memrd, mem_memwr}, 0);
    chk("rst_alu", mem_alu, 0);
    chk("rst_st", mem_store_data, 0);
    chk("rst_wn", mem_wn, 0);
    chk("rst_busy", ex_busy, 0);
    tick();

    // directed vector table
    for (int i = 0; i < 17; i++) begin
      id_valid = 1; id_enrw = 1; id_memrd = 0; id_memwr = (i == 4);
      id_aluop = vt[i].op; id_rd1 = vt[i].rd1; id_rd2 = vt[i].rd2; FA = vt[i].fa; FB = vt[i].fb;
      wb_fwd_data = vt[i].wb; id_alusrc = vt[i].alusrc; id_imm = vt[i].imm; id_wn = vt[i].wn;
      #1 chk($sformatf("v%0d_busy", i), ex_busy, 0);
      tick();
      chk($sformatf("v%0d_valid", i), mem_valid, 1);
      chk($sformatf("v%0d_alu", i), mem_alu, vt[i].exp_alu);
      chk($sformatf("v%0d_st", i), mem_store_data, vt[i].exp_st);
      chk($sformatf("v%0d_wn", i), mem_wn, vt[i].wn);
      chk($sformatf("v%0d_ctl", i), {mem_enrw, mem_memwr}, {1'b1, 1'(i == 4)});
    end
    id_memwr = 0;

    // MUL 0xFFFFFFFF * 3; rd1 changed mid-flight must not matter
    id_valid = 1; id_aluop = 4'd8; id_rd1 = 32'hFFFF_FFFF; id_rd2 = 3; FA = 0; FB = 0;
    id_alusrc = 0; id_wn = 4'd9; id_enrw = 1;
    busy_n = 0; bub_n = 0;
    #1;
    for (int k = 0; k < 34; k++) begin
      if (ex_busy) busy_n++;
      if (k == 2) id_rd1 = 32'd0;
      tick();
      if (k < 33 && !mem_valid) bub_n++;
    end
    chk("mul_busy_cycles", busy_n, 33);
    chk("mul_bubbles", bub_n, 33);
    chk("mul_valid", mem_valid, 1);
    chk("mul_prod", mem_alu, 32'hFFFF_FFFD);
    chk("mul_wn", mem_wn, 9);
    id_valid = 0;
    tick();
    chk("mul_after_busy", ex_busy, 0);

    // flush in MUL cycle 10 aborts the multiply
    id_valid = 1; id_aluop = 4'd8; id_rd1 = 7; id_rd2 = 6; id_wn = 4'd2;
    held = mem_alu;
    tick();
    for (int k = 1; k < 10; k++) tick();
    chk("fl_busy_pre", ex_busy, 1);
    ex_flush = 1;
    tick();
    ex_flush = 0; id_valid = 0;
    chk("fl_bubble", mem_valid, 0);
    #1 chk("fl_busy_next", ex_busy, 0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (mem_valid) seen = 1;
    end
    chk("fl_no_prod", seen, 0);
    chk("fl_alu_held", mem_alu, held);

    // flush on a valid ADD
    id_valid = 1; id_aluop = 0; id_rd1 = 50; id_rd2 = 50; ex_flush = 1;
    tick();
    ex_flush = 0;
    chk("fl_add_valid", mem_valid, 0);
    chk("fl_add_alu_held", mem_alu, held);

    // reset mid-multiply
    id_aluop = 4'd8; id_rd1 = 5; id_rd2 = 5;
    for (int k = 0; k < 6; k++) tick();
    #2 rst_n = 0;
    #1;
    chk("rm_alu", mem_alu, 0);
    chk("rm_valid", mem_valid, 0);
    id_valid = 0;
    #1 rst_n = 1;
    #1 chk("rm_busy", ex_busy, 0);
    tick();
    chk("rm_idle_valid", mem_valid, 0);
    id_valid = 1; id_aluop = 0; id_rd1 = 4; id_rd2 = 4; id_wn = 4'd6; FA = 0; FB = 0;
    tick();
    chk("rm_add_alu", mem_alu, 8);
    chk("rm_add_valid", mem_valid, 1);
    id_valid = 0;
    tick();

    // randomized single-cycle traffic against the model
    m_alu = mem_alu; m_st = mem_store_data; m_wn = mem_wn;
    for (int i = 0; i < 300; i++) begin
      logic v, fl;
      logic [3:0] op;
      v = ($urandom_range(0, 99) < 85); fl = ($urandom_range(0, 99) < 10);
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 7));
      id_valid = v; ex_flush = fl; id_aluop = op;
      id_rd1 = $urandom; id_rd2 = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
      id_imm = $urandom; id_alusrc = 1'($urandom); FA = 2'($urandom); FB = 2'($urandom);
      wb_fwd_data = $urandom; id_wn = 4'($urandom); id_enrw = 1'($urandom);
      id_memrd = 1'($urandom); id_memwr = 1'($urandom);
      a  = pick(FA, id_rd1, m_alu, wb_fwd_data);
      bf = pick(FB, id_rd2, m_alu, wb_fwd_data);
      b  = id_alusrc ? id_imm : bf;
      if (v && !fl) begin
        m_alu = ref_alu(op, a, b); m_st = bf; m_wn = id_wn;
      end
      tick();
      chk($sformatf("r%0d_valid", i), mem_valid, (v && !fl));
      chk($sformatf("r%0d_ctl", i), {mem_enrw, mem_memrd, mem_memwr},
          (v && !fl) ? {id_enrw, id_memrd, id_memwr} : 3'b000);
      chk($sformatf("r%0d_alu", i), mem_alu, m_alu);
      chk($sformatf("r%0d_st", i), mem_store_data, m_st);
      chk($sformatf("r%0d_wn", i), mem_wn, m_wn);
    end
    ex_flush = 0; id_valid = 0;
    tick();

    // randomized multiplies with forwarded operands
    for (int i = 0; i < 8; i++) begin
      id_valid = 1; id_aluop = 4'd8; id_rd1 = $urandom; id_rd2 = $urandom;
      FA = 2'($urandom); FB = 2'($urandom); wb_fwd_data = $urandom; id_imm = $urandom;
      id_alusrc = 1'($urandom); id_wn = 4'($urandom);
      a  = pick(FA, id_rd1, m_alu, wb_fwd_data);
      bf = pick(FB, id_rd2, m_alu, wb_fwd_data);
      b  = id_alusrc ? id_imm : bf;
      m_alu = ref_alu(4'd8, a, b); m_st = bf; m_wn = id_wn;
      waited = 0;
      seen = 0;
      while (!seen && waited < 50) begin
        tick();
        waited++;
        if (mem_valid) seen = 1;
      end
      if (!seen) begin
        n_cmp++; n_bad++;
        $display("FAIL rm%0d_timeout: no product after %0d cycles, expected 34", i, waited);
      end
      id_valid = 0;
      chk($sformatf("rm%0d_lat", i), waited, 34);
      chk($sformatf("rm%0d_prod", i), mem_alu, m_alu);
      chk($sformatf("rm%0d_st", i), mem_store_data, m_st);
      chk($sformatf("rm%0d_wn", i), mem_wn, m_wn);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
